// File: rtl/code_lock_if.sv
// code_lock_if: code/button inputs and lock status outputs of the code lock controller
interface code_lock_if #(
  parameter int CODE_W = 7,
  parameter int MAX_TRIES = 3
);
  logic [CODE_W-1:0] code_in;
  logic enter_btn;
  logic set_btn;
  logic opened;
  logic alarm;
  logic locked_out;
  logic [$clog2(MAX_TRIES+1)-1:0] tries_left;
  logic [2:0] state;
  modport master (output code_in, enter_btn, set_btn, input opened, alarm, locked_out, tries_left, state);
  modport slave (input code_in, enter_btn, set_btn, output opened, alarm, locked_out, tries_left, state);
endinterface

// File: rtl/code_lock_ctrl.sv
// code_lock_ctrl: settable-code lock FSM with failure lockout, entry/relock timeouts and alarm blink
module code_lock_ctrl #(
  parameter int CODE_W = 7,
  parameter logic [CODE_W-1:0] DEFAULT_CODE = '0,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int LOCKOUT_CYCLES = 65535,
  parameter int BLINK_BIT = 8
) (
  input logic clk,
  input logic rst_n,
  code_lock_if.slave bus
);
  localparam int FW = $clog2(MAX_TRIES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES > LOCKOUT_CYCLES ? TIMEOUT_CYCLES : LOCKOUT_CYCLES);
  typedef enum logic [2:0] {
    IDLE = 3'b000, SET_AWAIT = 3'b001, OPENED = 3'b010,
    ALARM = 3'b011, INPUT = 3'b100, LOCKOUT = 3'b101
  } state_t;
  state_t state_q, state_n;
  logic [CODE_W-1:0] code_q, code_n;
  logic [FW-1:0] fail_q, fail_n;
  logic [TW-1:0] timer_q;
  logic [BLINK_BIT:0] blink_q;
  logic [1:0] ent_s, set_s, arm;
  logic ent_h, set_h, enter_ev, set_ev, ent, tmo, lock_done;
  // history is forced high until the synchroniser has filled, so a button held through reset stays silent
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ent_s <= '0;
      set_s <= '0;
      ent_h <= 1'b1;
      set_h <= 1'b1;
      arm <= '0;
      blink_q <= '0;
    end else begin
      ent_s <= {ent_s[0], bus.enter_btn};
      set_s <= {set_s[0], bus.set_btn};
      ent_h <= ent_s[1] | ~arm[1];
      set_h <= set_s[1] | ~arm[1];
      arm <= {arm[0], 1'b1};
      blink_q <= blink_q + 1'b1;
    end
  assign enter_ev = ent_s[1] & ~ent_h;
  assign set_ev = set_s[1] & ~set_h;
  assign ent = enter_ev & ~set_ev;
  assign tmo = timer_q == TW'(TIMEOUT_CYCLES - 1);
  assign lock_done = timer_q == TW'(LOCKOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      code_q <= DEFAULT_CODE;
      fail_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_n;
      code_q <= code_n;
      fail_q <= fail_n;
      timer_q <= (state_n != state_q) ? '0 : (&timer_q) ? timer_q : timer_q + 1'b1;
    end
  always_comb begin
    state_n = state_q;
    code_n = code_q;
    fail_n = fail_q;
    case (state_q)
      IDLE: state_n = ent ? INPUT : IDLE;
      INPUT:
        if (ent) begin
          if (bus.code_in == code_q) begin
            state_n = OPENED;
            fail_n = '0;
          end else begin
            fail_n = fail_q + 1'b1;
            state_n = (fail_n == FW'(MAX_TRIES)) ? LOCKOUT : ALARM;
          end
        end else if (set_ev || tmo) state_n = IDLE;
      OPENED: state_n = set_ev ? SET_AWAIT : (ent || tmo) ? IDLE : OPENED;
      SET_AWAIT: begin
        code_n = set_ev ? bus.code_in : code_q;
        state_n = (set_ev || ent || tmo) ? IDLE : SET_AWAIT;
      end
      ALARM: state_n = ent ? IDLE : ALARM;
      LOCKOUT:
        if (lock_done) begin
          state_n = IDLE;
          fail_n = '0;
        end
      default: state_n = IDLE;
    endcase
  end
  assign bus.opened = state_q == OPENED;
  assign bus.locked_out = state_q == LOCKOUT;
  assign bus.alarm = (state_q == ALARM || state_q == LOCKOUT) & blink_q[BLINK_BIT];
  assign bus.tries_left = FW'(MAX_TRIES) - fail_q;
  assign bus.state = state_q;
endmodule

// File: tb/tb_code_lock_ctrl.sv
// tb_code_lock_ctrl: table-driven transitions plus timing/reset corner sequences for code_lock_ctrl
module tb_code_lock_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  code_lock_if #(.CODE_W(7), .MAX_TRIES(3)) bus ();
  code_lock_ctrl #(
    .CODE_W(7), .DEFAULT_CODE(7'h00), .MAX_TRIES(3),
    .TIMEOUT_CYCLES(20), .LOCKOUT_CYCLES(30), .BLINK_BIT(2)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic e;
    logic s;
    logic [6:0] c;
    logic [2:0] st;
    logic [1:0] tl;
  } vec_t;
  vec_t vec [28];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic rise(input logic e, input logic s, input logic [6:0] c);
    bus.code_in = c;
    bus.enter_btn = e;
    bus.set_btn = s;
  endtask
  task automatic press(input logic e, input logic s, input logic [6:0] c);
    rise(e, s, c);
    step(3);
    bus.enter_btn = 1'b0;
    bus.set_btn = 1'b0;
    step(3);
  endtask
  task automatic chk_state(input string name, input logic [2:0] st, input logic [1:0] tl);
    chk({name, " state"}, 32'(bus.state), 32'(st));
    chk({name, " tries_left"}, 32'(bus.tries_left), 32'(tl));
    chk({name, " opened"}, 32'(bus.opened), 32'(st == 3'b010));
    chk({name, " locked_out"}, 32'(bus.locked_out), 32'(st == 3'b101));
  endtask
  initial begin
    int hi;
    vec[0]  = '{1, 0, 7'h00, 3'b100, 2'd3};
    vec[1]  = '{1, 0, 7'h00, 3'b010, 2'd3};
    vec[2]  = '{0, 1, 7'h2A, 3'b001, 2'd3};
    vec[3]  = '{0, 1, 7'h2A, 3'b000, 2'd3};
    vec[4]  = '{1, 0, 7'h00, 3'b100, 2'd3};
    vec[5]  = '{1, 0, 7'h2A, 3'b010, 2'd3};
    vec[6]  = '{1, 0, 7'h00, 3'b000, 2'd3};
    vec[7]  = '{1, 0, 7'h00, 3'b100, 2'd3};
    vec[8]  = '{0, 1, 7'h00, 3'b000, 2'd3};
    vec[9]  = '{1, 0, 7'h00, 3'b100, 2'd3};
    vec[10] = '{1, 0, 7'h2A, 3'b010, 2'd3};
    vec[11] = '{0, 1, 7'h00, 3'b001, 2'd3};
    vec[12] = '{1, 0, 7'h11, 3'b000, 2'd3};
    vec[13] = '{1, 0, 7'h00, 3'b100, 2'd3};
    vec[14] = '{1, 0, 7'h2A, 3'b010, 2'd3};
    vec[15] = '{1, 1, 7'h55, 3'b001, 2'd3};
    vec[16] = '{0, 1, 7'h55, 3'b000, 2'd3};
    vec[17] = '{1, 0, 7'h00, 3'b100, 2'd3};
    vec[18] = '{1, 0, 7'h00, 3'b011, 2'd2};
    vec[19] = '{0, 1, 7'h00, 3'b011, 2'd2};
    vec[20] = '{1, 0, 7'h00, 3'b000, 2'd2};
    vec[21] = '{1, 0, 7'h00, 3'b100, 2'd2};
    vec[22] = '{1, 0, 7'h54, 3'b011, 2'd1};
    vec[23] = '{1, 0, 7'h00, 3'b000, 2'd1};
    vec[24] = '{1, 0, 7'h00, 3'b100, 2'd1};
    vec[25] = '{1, 0, 7'h2A, 3'b101, 2'd0};
    vec[26] = '{1, 0, 7'h00, 3'b101, 2'd0};
    vec[27] = '{0, 1, 7'h00, 3'b101, 2'd0};
    rise(0, 0, 7'h00);
    step(3);
    chk_state("reset", 3'b000, 2'd3);
    chk("reset alarm", 32'(bus.alarm), 0);
    rst_n = 1'b1;
    step(3);
    for (int i = 0; i < 28; i++) begin
      press(vec[i].e, vec[i].s, vec[i].c);
      chk_state($sformatf("vec%0d", i), vec[i].st, vec[i].tl);
      if (vec[i].st != 3'b011 && vec[i].st != 3'b101) chk($sformatf("vec%0d alarm", i), 32'(bus.alarm), 0);
    end
    // LOCKOUT was entered 15 cycles ago; ignored presses must not restart the timer
    step(14);
    chk_state("lockout 29", 3'b101, 2'd0);
    step(1);
    chk_state("lockout 30", 3'b000, 2'd3);
    rise(1, 0, 7'h55);
    step(2);
    chk("enter lat 2", 32'(bus.state), 32'(3'b000));
    step(1);
    chk("enter lat 3", 32'(bus.state), 32'(3'b100));
    rise(0, 0, 7'h55);
    step(3);
    rise(1, 0, 7'h55);
    step(2);
    chk("open lat 2", 32'(bus.opened), 0);
    step(1);
    chk("open lat 3", 32'(bus.opened), 1);
    rise(0, 0, 7'h55);
    step(3);
    step(16);
    chk("opened 19", 32'(bus.state), 32'(3'b010));
    step(1);
    chk("opened relock", 32'(bus.state), 32'(3'b000));
    press(1, 0, 7'h00);
    step(16);
    chk("input 19", 32'(bus.state), 32'(3'b100));
    step(1);
    chk("input timeout", 32'(bus.state), 32'(3'b000));
    press(1, 0, 7'h00);
    press(1, 0, 7'h7F);
    step(40);
    chk_state("alarm holds", 3'b011, 2'd2);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      hi += int'(bus.alarm);
    end
    chk("alarm blink", 32'(hi), 4);
    press(1, 0, 7'h00);
    chk("alarm exit", 32'(bus.state), 32'(3'b000));
    rise(1, 0, 7'h00);
    rst_n = 1'b0;
    step(2);
    chk_state("held reset", 3'b000, 2'd3);
    rst_n = 1'b1;
    step(10);
    chk("held no event", 32'(bus.state), 32'(3'b000));
    rise(0, 0, 7'h00);
    step(3);
    press(1, 0, 7'h00);
    chk("after held", 32'(bus.state), 32'(3'b100));
    press(0, 1, 7'h00);
    for (int i = 0; i < 3; i++) begin
      press(1, 0, 7'h00);
      press(1, 0, 7'h7F);
      chk_state($sformatf("fail%0d", i), (i < 2) ? 3'b011 : 3'b101, 2'(2 - i));
      if (i < 2) press(1, 0, 7'h00);
    end
    #2 rst_n = 1'b0;
    #1;
    chk_state("async reset", 3'b000, 2'd3);
    chk("async reset alarm", 32'(bus.alarm), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(3);
    press(1, 0, 7'h00);
    press(1, 0, 7'h00);
    chk_state("code restored", 3'b010, 2'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
